// File: rtl/ssb_pkg.sv
// SSB grid constants and demapper FSM state type.
package ssb_pkg;

  localparam int SSB_SC           = 240;
  localparam int SSS_START        = 56;
  localparam int SSS_LEN          = 127;
  localparam int SSS_END          = SSS_START + SSS_LEN - 1;
  localparam int PBCH_RE          = 432;
  localparam int PBCH_SB_LO_END   = 47;
  localparam int PBCH_SB_HI_START = 192;

  typedef enum logic [1:0] {
    IDLE,
    PBCH_SYM,
    SSS_SYM
  } demap_state_t;

endpackage

// File: rtl/axis_fifo_fwft.sv
// First-word-fall-through AXI-stream FIFO; drop flags a write lost to full.
module axis_fifo_fwft #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          drop,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign full     = count == (AW+1)'(DEPTH);
  assign m_tvalid = count != '0;
  assign do_rd    = m_tvalid & m_tready;
  // A read in the same cycle frees the slot, so full+read still accepts.
  assign do_wr    = wr_en & (~full | do_rd);
  assign drop     = wr_en & ~do_wr;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/ssb_demapper.sv
// SSB resource-element demapper: SSS and PBCH REs to buffered AXI streams.
// PBCH path is built only when SSB_DEMAPPER_PBCH_EN is defined.
module ssb_demapper
  import ssb_pkg::*;
#(
  parameter int FFT_LEN    = 256,
  parameter int IN_DW      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             s_axis_in_tlast,
  input  logic             SSS_valid_i,
  input  logic             PBCH_valid_i,
  output logic [IN_DW-1:0] m_axis_sss_tdata,
  output logic             m_axis_sss_tvalid,
  input  logic             m_axis_sss_tready,
  output logic             m_axis_sss_tlast,
  output logic [IN_DW-1:0] m_axis_pbch_tdata,
  output logic             m_axis_pbch_tvalid,
  input  logic             m_axis_pbch_tready,
  output logic             m_axis_pbch_tlast,
  output logic [9:0]       m_axis_pbch_tuser,
  output logic             overflow_o
);

  localparam int OFS = (FFT_LEN - SSB_SC) / 2;

  demap_state_t state;
  demap_state_t mode;
  logic [7:0]   bin_cnt;
  logic [7:0]   k;
  logic [1:0]   sym_cnt;
  logic [1:0]   eff_cnt;
  logic         prev_sss;
  logic         in_ssb;
  logic         last_bin;
  logic         cls_sss;
  logic         cls_sss_last;
  logic         cls_pbch;
  logic         cls_pbch_last;
  logic [1:0]   cls_sym;

  logic             st_sss_we;
  logic             st_sss_last;
  logic [IN_DW-1:0] st_data;
  logic             sss_drop;
  logic             pbch_drop;

  always_comb begin
    mode = state;
    if (state == IDLE) begin
      if (SSS_valid_i)       mode = SSS_SYM;
      else if (PBCH_valid_i) mode = PBCH_SYM;
    end
    // Resync the symbol index when a PBCH symbol does not follow SSS.
    eff_cnt = sym_cnt;
    if (state == IDLE && mode == PBCH_SYM &&
        sym_cnt != 2'd0 && !prev_sss)
      eff_cnt = 2'd0;
    k        = bin_cnt - 8'(OFS);
    in_ssb   = bin_cnt >= 8'(OFS) && bin_cnt < 8'(OFS + SSB_SC);
    last_bin = s_axis_in_tlast || bin_cnt == 8'(FFT_LEN - 1);
    cls_sss       = 1'b0;
    cls_sss_last  = 1'b0;
    cls_pbch      = 1'b0;
    cls_pbch_last = 1'b0;
    cls_sym       = eff_cnt;
    unique case (1'b1)
      (mode == PBCH_SYM): begin
        cls_pbch      = in_ssb;
        cls_pbch_last = eff_cnt == 2'd2 && k == 8'(SSB_SC - 1);
      end
      (mode == SSS_SYM): begin
        cls_sym = 2'd1;
        if (in_ssb && k >= 8'(SSS_START) && k <= 8'(SSS_END)) begin
          cls_sss      = 1'b1;
          cls_sss_last = k == 8'(SSS_END);
        end
        cls_pbch = in_ssb && (k <= 8'(PBCH_SB_LO_END) ||
                              k >= 8'(PBCH_SB_HI_START));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      bin_cnt     <= '0;
      sym_cnt     <= '0;
      prev_sss    <= 1'b0;
      st_sss_we   <= 1'b0;
      st_sss_last <= 1'b0;
      st_data     <= '0;
      overflow_o  <= 1'b0;
    end else begin
      st_sss_we   <= s_axis_in_tvalid & cls_sss;
      st_sss_last <= cls_sss_last;
      st_data     <= s_axis_in_tdata;
      overflow_o  <= overflow_o | sss_drop | pbch_drop;
      if (s_axis_in_tvalid) begin
        bin_cnt <= last_bin ? 8'd0 : bin_cnt + 8'd1;
        if (mode != IDLE) begin
          if (last_bin) begin
            state    <= IDLE;
            sym_cnt  <= (eff_cnt == 2'd2) ? 2'd0 : eff_cnt + 2'd1;
            prev_sss <= mode == SSS_SYM;
          end else begin
            state   <= mode;
            sym_cnt <= eff_cnt;
          end
        end
      end
    end
  end

  axis_fifo_fwft #(
    .DW    (IN_DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_sss_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en    (st_sss_we),
    .wr_data  ({st_sss_last, st_data}),
    .drop     (sss_drop),
    .m_tdata  ({m_axis_sss_tlast, m_axis_sss_tdata}),
    .m_tvalid (m_axis_sss_tvalid),
    .m_tready (m_axis_sss_tready)
  );

`ifdef SSB_DEMAPPER_PBCH_EN
  logic       st_pbch_we;
  logic       st_pbch_last;
  logic [9:0] st_user;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      st_pbch_we   <= 1'b0;
      st_pbch_last <= 1'b0;
      st_user      <= '0;
    end else begin
      st_pbch_we   <= s_axis_in_tvalid & cls_pbch;
      st_pbch_last <= cls_pbch_last;
      st_user      <= {cls_sym, k};
    end
  end

  axis_fifo_fwft #(
    .DW    (IN_DW + 11),
    .DEPTH (FIFO_DEPTH)
  ) u_pbch_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en    (st_pbch_we),
    .wr_data  ({st_pbch_last, st_user, st_data}),
    .drop     (pbch_drop),
    .m_tdata  ({m_axis_pbch_tlast, m_axis_pbch_tuser,
                m_axis_pbch_tdata}),
    .m_tvalid (m_axis_pbch_tvalid),
    .m_tready (m_axis_pbch_tready)
  );
`else
  logic unused_pbch;

  assign unused_pbch = ^{m_axis_pbch_tready, cls_pbch,
                         cls_pbch_last, cls_sym};
  assign pbch_drop          = 1'b0;
  assign m_axis_pbch_tdata  = '0;
  assign m_axis_pbch_tvalid = 1'b0;
  assign m_axis_pbch_tlast  = 1'b0;
  assign m_axis_pbch_tuser  = '0;
`endif

endmodule
